// File: rtl/car_drive_ctrl.sv
// Two-motor car drive controller: synchronised and debounced key commands, dead-time on
// direction changes, soft-start PWM ramp. Define CAR_BEEP_EN to build the motion buzzer.
module car_drive_ctrl #(
    parameter int PWM_W    = 8,
    parameter int DEB_CYC  = 50000,
    parameter int DEAD_CYC = 100000,
    parameter int RAMP_DIV = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       key,
    input  logic             ena,
    input  logic [PWM_W-1:0] speed,
    output logic             zuo1,
    output logic             zuo2,
    output logic             you1,
    output logic             you2,
    output logic             en1,
    output logic             en2,
    output logic             feng,
    output logic             beep,
    output logic             led1
);

    localparam int DEB_W  = (DEB_CYC  > 1) ? $clog2(DEB_CYC)  : 1;
    localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [DEB_W-1:0]  DEB_LOAD = DEB_W'(DEB_CYC - 2);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYC - 1);
    localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_CYC - 1);
    localparam logic [RAMP_W-1:0] RAMP_MAX = RAMP_W'(RAMP_DIV - 1);

    typedef enum logic [2:0] {
        CMD_IDLE, CMD_FWD, CMD_REV, CMD_LEFT, CMD_RIGHT, CMD_STOP
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE, ST_DEAD, ST_RUN
    } state_t;

    function automatic cmd_t decode_key(input logic [3:0] k);
        case (k)
            4'b1000: return CMD_FWD;
            4'b0100: return CMD_REV;
            4'b0010: return CMD_LEFT;
            4'b0001: return CMD_RIGHT;
            4'b0011: return CMD_STOP;
            default: return CMD_IDLE;
        endcase
    endfunction

    function automatic logic is_motion(input cmd_t c);
        return (c == CMD_FWD) || (c == CMD_REV) || (c == CMD_LEFT) || (c == CMD_RIGHT);
    endfunction

    // {zuo1, zuo2, you1, you2}
    function automatic logic [3:0] dir_pattern(input cmd_t c);
        case (c)
            CMD_FWD:   return 4'b1010;
            CMD_REV:   return 4'b0101;
            CMD_LEFT:  return 4'b0010;
            CMD_RIGHT: return 4'b1000;
            default:   return 4'b0000;
        endcase
    endfunction

    logic [3:0]       key_p0, key_p1;
    logic             ena_p0, ena_p1;
    logic [3:0]       deb_key;
    logic [DEB_W-1:0] deb_cnt;
    cmd_t             cmd;
    cmd_t             eff_cmd;

    state_t            state, state_nxt;
    cmd_t              dir, dir_nxt;
    logic [DEAD_W-1:0] dead_cnt, dead_nxt;
    logic [RAMP_W-1:0] ramp_cnt, ramp_nxt;
    logic [PWM_W-1:0]  duty, duty_nxt;
    logic [PWM_W-1:0]  pwm_cnt, pwm_nxt;

    logic [3:0] dir_bits_nxt;
    logic       en_nxt;
    logic       led1_nxt;
    logic       feng_nxt;
    logic       beep_nxt;

    // Stage p0/p1: two-flop synchronisers for the asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_p0 <= '0;
            key_p1 <= '0;
            ena_p0 <= 1'b0;
            ena_p1 <= 1'b0;
        end else begin
            key_p0 <= key;
            key_p1 <= key_p0;
            ena_p0 <= ena;
            ena_p1 <= ena_p0;
        end
    end

    // Debounce: the first differing sample restarts the run, the DEB_CYC-th identical one loads cmd
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_key <= '0;
            deb_cnt <= '0;
            cmd     <= CMD_IDLE;
        end else if (key_p1 != deb_key) begin
            deb_key <= key_p1;
            deb_cnt <= '0;
        end else begin
            if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + DEB_W'(1);
            if (deb_cnt == DEB_LOAD) cmd <= decode_key(deb_key);
        end
    end

    assign eff_cmd = ena_p1 ? CMD_IDLE : cmd;
    assign pwm_nxt = pwm_cnt + PWM_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dir      <= CMD_IDLE;
            dead_cnt <= '0;
            ramp_cnt <= '0;
            duty     <= '0;
            pwm_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            dir      <= dir_nxt;
            dead_cnt <= dead_nxt;
            ramp_cnt <= ramp_nxt;
            duty     <= duty_nxt;
            pwm_cnt  <= pwm_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        dead_nxt  = dead_cnt;
        ramp_nxt  = ramp_cnt;
        duty_nxt  = duty;
        case (state)
            ST_IDLE: begin
                dead_nxt = '0;
                ramp_nxt = '0;
                duty_nxt = '0;
                if (is_motion(eff_cmd)) begin
                    state_nxt = ST_DEAD;
                    dir_nxt   = eff_cmd;
                end
            end
            ST_DEAD: begin
                ramp_nxt = '0;
                duty_nxt = '0;
                if (!is_motion(eff_cmd)) begin
                    state_nxt = ST_IDLE;
                    dir_nxt   = CMD_IDLE;
                    dead_nxt  = '0;
                end else if (eff_cmd != dir) begin
                    // a different direction restarts the dead time; the pending one keeps counting
                    dir_nxt  = eff_cmd;
                    dead_nxt = '0;
                end else if (dead_cnt == DEAD_MAX) begin
                    state_nxt = ST_RUN;
                    dead_nxt  = '0;
                end else begin
                    dead_nxt = dead_cnt + DEAD_W'(1);
                end
            end
            ST_RUN: begin
                if (!is_motion(eff_cmd)) begin
                    state_nxt = ST_IDLE;
                    dir_nxt   = CMD_IDLE;
                    ramp_nxt  = '0;
                    duty_nxt  = '0;
                end else if (eff_cmd != dir) begin
                    state_nxt = ST_DEAD;
                    dir_nxt   = eff_cmd;
                    dead_nxt  = '0;
                    ramp_nxt  = '0;
                    duty_nxt  = '0;
                end else if (speed < duty) begin
                    duty_nxt = speed;
                    ramp_nxt = '0;
                end else if (ramp_cnt == RAMP_MAX) begin
                    ramp_nxt = '0;
                    if (duty != speed) duty_nxt = duty + PWM_W'(1);
                end else begin
                    ramp_nxt = ramp_cnt + RAMP_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                dir_nxt   = CMD_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next-state values so the output flops line up with the FSM
    always_comb begin
        dir_bits_nxt = 4'b0000;
        en_nxt       = 1'b0;
        led1_nxt     = 1'b1;
        feng_nxt     = 1'b1;
        case (state_nxt)
            ST_IDLE: feng_nxt = (eff_cmd != CMD_STOP);
            ST_DEAD: led1_nxt = 1'b0;
            ST_RUN: begin
                led1_nxt     = 1'b0;
                dir_bits_nxt = dir_pattern(dir_nxt);
                en_nxt       = (pwm_nxt < duty_nxt);
            end
            default: ;
        endcase
    end

`ifdef CAR_BEEP_EN
    logic [23:0] beep_cnt, beep_cnt_nxt;

    assign beep_cnt_nxt = beep_cnt + 24'd1;
    assign beep_nxt     = (state_nxt != ST_IDLE) && beep_cnt_nxt[2] && beep_cnt_nxt[23];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) beep_cnt <= '0;
        else        beep_cnt <= beep_cnt_nxt;
    end
`else
    assign beep_nxt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zuo1 <= 1'b0;
            zuo2 <= 1'b0;
            you1 <= 1'b0;
            you2 <= 1'b0;
            en1  <= 1'b0;
            en2  <= 1'b0;
            feng <= 1'b1;
            beep <= 1'b0;
            led1 <= 1'b1;
        end else begin
            zuo1 <= dir_bits_nxt[3];
            zuo2 <= dir_bits_nxt[2];
            you1 <= dir_bits_nxt[1];
            you2 <= dir_bits_nxt[0];
            en1  <= en_nxt;
            en2  <= en_nxt;
            feng <= feng_nxt;
            beep <= beep_nxt;
            led1 <= led1_nxt;
        end
    end

endmodule

// File: tb/tb_car_drive_ctrl.sv
// Bench for car_drive_ctrl with small timing parameters: vector table plus hand-written
// sequences for debounce, ena override, PWM duty and asynchronous reset.
module tb_car_drive_ctrl;

    localparam int PWM_W    = 4;
    localparam int DEB_CYC  = 4;
    localparam int DEAD_CYC = 8;
    localparam int RAMP_DIV = 2;

`ifdef CAR_BEEP_EN
    localparam bit CHK_BEEP = 1'b0;
`else
    localparam bit CHK_BEEP = 1'b1;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       key   = 4'b0000;
    logic             ena   = 1'b0;
    logic [PWM_W-1:0] speed = '0;
    logic zuo1, zuo2, you1, you2, en1, en2, feng, beep, led1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [3:0]       key;
        logic             ena;
        logic [PWM_W-1:0] speed;
        int               cyc;
        logic [3:0]       dir;
        logic             led1;
        logic             feng;
        logic             chk_en;
        logic             en;
    } vec_t;

    typedef struct {
        logic [3:0] dir;
        logic       led1;
        logic       feng;
        logic       chk_en;
        logic       en;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    car_drive_ctrl #(
        .PWM_W   (PWM_W),
        .DEB_CYC (DEB_CYC),
        .DEAD_CYC(DEAD_CYC),
        .RAMP_DIV(RAMP_DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .key  (key),
        .ena  (ena),
        .speed(speed),
        .zuo1 (zuo1),
        .zuo2 (zuo2),
        .you1 (you1),
        .you2 (you2),
        .en1  (en1),
        .en2  (en2),
        .feng (feng),
        .beep (beep),
        .led1 (led1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_row(input logic [3:0] k, input logic e, input logic [PWM_W-1:0] s,
                           input int c, input logic [3:0] d, input logic l, input logic f,
                           input logic ce, input logic en);
        vec_t v;
        v.key = k; v.ena = e; v.speed = s; v.cyc = c;
        v.dir = d; v.led1 = l; v.feng = f; v.chk_en = ce; v.en = en;
        tbl.push_back(v);
    endtask

    task automatic expect_out(input logic [3:0] d, input logic l, input logic f,
                              input logic ce, input logic en);
        exp_t x;
        x.dir = d; x.led1 = l; x.feng = f; x.chk_en = ce; x.en = en;
        exp_q.push_back(x);
    endtask

    task automatic check_out(input string name);
        exp_t       x;
        logic [3:0] act;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: no expected record queued", name);
            return;
        end
        x   = exp_q.pop_front();
        act = {zuo1, zuo2, you1, you2};
        if (act !== x.dir || led1 !== x.led1 || feng !== x.feng ||
            (CHK_BEEP && beep !== 1'b0) ||
            (x.chk_en && (en1 !== x.en || en2 !== x.en))) begin
            n_errors++;
            $display("FAIL %s: got dir=%b led1=%b feng=%b en1=%b en2=%b beep=%b, need dir=%b led1=%b feng=%b en=%b(%s) beep=0",
                     name, act, led1, feng, en1, en2, beep, x.dir, x.led1, x.feng, x.en,
                     x.chk_en ? "checked" : "ignored");
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, need %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic count_en(input int n, output int c1, output int c2);
        c1 = 0;
        c2 = 0;
        repeat (n) begin
            @(negedge clk);
            c1 += int'(en1);
            c2 += int'(en2);
        end
    endtask

    // Invariants checked every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if ((en1 !== en2) || (en1 === 1'b1 && ({zuo1, zuo2, you1, you2} == 4'b0000 || led1 !== 1'b0)) ||
                (CHK_BEEP && beep !== 1'b0)) begin
                n_errors++;
                $display("FAIL monitor @%0t: got en1=%b en2=%b dir=%b%b%b%b led1=%b beep=%b, need en1==en2, en only while driving, beep=0",
                         $time, en1, en2, zuo1, zuo2, you1, you2, led1, beep);
            end
        end
    end

    initial begin
        int c1, c2;

        // key, ena, speed, cycles, dir, led1, feng, chk_en, en
        add_row(4'b1000, 1'b0, 4'd6,  6, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        add_row(4'b1000, 1'b0, 4'd6,  1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        add_row(4'b1000, 1'b0, 4'd6,  7, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        add_row(4'b1000, 1'b0, 4'd6,  1, 4'b1010, 1'b0, 1'b1, 1'b1, 1'b0);
        add_row(4'b1000, 1'b0, 4'd6, 40, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0);
        add_row(4'b0100, 1'b0, 4'd6,  6, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0);
        add_row(4'b0100, 1'b0, 4'd6,  1, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        add_row(4'b0100, 1'b0, 4'd6,  7, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        add_row(4'b0100, 1'b0, 4'd6,  1, 4'b0101, 1'b0, 1'b1, 1'b1, 1'b0);
        add_row(4'b0100, 1'b0, 4'd6, 30, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
        add_row(4'b0010, 1'b0, 4'd6,  7, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        add_row(4'b0010, 1'b0, 4'd6,  8, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
        add_row(4'b0001, 1'b0, 4'd6,  7, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        add_row(4'b0001, 1'b0, 4'd6,  8, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0);
        add_row(4'b0011, 1'b0, 4'd6,  6, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0);
        add_row(4'b0011, 1'b0, 4'd6,  1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        add_row(4'b0011, 1'b0, 4'd6,  5, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        add_row(4'b0000, 1'b0, 4'd6,  6, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        add_row(4'b0000, 1'b0, 4'd6,  1, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);

        // Reset state while rst_n is held low
        tick(2);
        expect_out(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        check_out("reset_hold");
        rst_n = 1'b1;

        // Idle with no key for 100 cycles
        for (int i = 0; i < 100; i++) begin
            expect_out(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
            tick(1);
            check_out($sformatf("idle_c%0d", i));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            key   = tbl[i].key;
            ena   = tbl[i].ena;
            speed = tbl[i].speed;
            expect_out(tbl[i].dir, tbl[i].led1, tbl[i].feng, tbl[i].chk_en, tbl[i].en);
            tick(tbl[i].cyc);
            check_out($sformatf("row%0d", i));
        end

        // Three-cycle glitch must be ignored
        key = 4'b1000;
        tick(3);
        key = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            expect_out(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
            tick(1);
            check_out($sformatf("glitch_c%0d", i));
        end

        // Four-cycle press is accepted, then the release debounces back to idle
        key = 4'b1000;
        expect_out(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(4);
        key = 4'b0000;
        tick(2);
        check_out("press4_before");
        expect_out(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        check_out("press4_dead");
        expect_out(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(3);
        check_out("press4_dead_hold");
        expect_out(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        check_out("press4_release");

        // Duty: settle, reduce, ramp up, full scale, zero
        key   = 4'b1000;
        speed = 4'd6;
        expect_out(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(14);
        check_out("duty_dead");
        expect_out(4'b1010, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        check_out("duty_run_entry");
        tick(20);
        count_en(16, c1, c2);
        check_range("duty6_en1", c1, 6, 6);
        check_range("duty6_en2", c2, 6, 6);
        speed = 4'd2;
        tick(2);
        count_en(16, c1, c2);
        check_range("duty_drop_en1", c1, 2, 2);
        speed = 4'd15;
        count_en(16, c1, c2);
        check_range("duty_ramp_en1", c1, 2, 10);
        tick(30);
        count_en(16, c1, c2);
        check_range("duty15_en1", c1, 15, 15);
        check_range("duty15_en2", c2, 15, 15);
        speed = 4'd0;
        tick(2);
        count_en(16, c1, c2);
        check_range("duty0_en1", c1, 0, 0);

        // ena forces idle within three cycles and releases through dead time
        speed = 4'd6;
        tick(20);
        ena = 1'b1;
        expect_out(4'b1010, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(2);
        check_out("ena_c2");
        expect_out(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        check_out("ena_c3");
        for (int i = 0; i < 10; i++) begin
            expect_out(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
            tick(1);
            check_out($sformatf("ena_hold_c%0d", i));
        end
        ena = 1'b0;
        expect_out(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(2);
        check_out("ena_rel_c2");
        expect_out(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        check_out("ena_rel_dead");
        expect_out(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(7);
        check_out("ena_rel_dead_end");
        expect_out(4'b1010, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        check_out("ena_rel_run");

        // Asynchronous reset in the middle of a ramp
        speed = 4'd15;
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        check_out("async_reset");
        @(negedge clk);
        expect_out(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        check_out("async_reset_hold");
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expect_out(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
            tick(1);
            check_out($sformatf("post_reset_c%0d", i));
        end
        expect_out(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        check_out("post_reset_dead");
        expect_out(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(7);
        check_out("post_reset_dead_end");
        expect_out(4'b1010, 1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        check_out("post_reset_run");

        key = 4'b0000;
        expect_out(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(20);
        check_out("final_idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/car_drive_ctrl.md
CAR_DRIVE_CTRL -- requirements
Module: car_drive_ctrl

Interface
REQ-001 SHALL have parameter PWM_W, 8, width of the speed setpoint and PWM counter (2..12).
REQ-002 SHALL have parameter DEB_CYC, 50000, consecutive stable cycles required before a key change is accepted (>=2).
REQ-003 SHALL have parameter DEAD_CYC, 100000, bridge-off cycles inserted on any direction change (>=1).
REQ-004 SHALL have parameter RAMP_DIV, 4096, cycles between successive duty increments of the soft-start ramp (>=1).
REQ-005 SHALL have port clk input 1, the single system clock; all state is clocked on its rising edge.
REQ-006 SHALL have port rst_n input 1, asynchronous active-low reset.
REQ-007 SHALL have port key input 4, raw asynchronous drive command buttons, encoding per REQ-013.
REQ-008 SHALL have port ena input 1, asynchronous forced-stop: 1 = halt, 0 = run.
REQ-009 SHALL have port speed input PWM_W, target duty; sampled every cycle.
REQ-010 SHALL have ports zuo1, zuo2, you1, you2, each output 1: left/right H-bridge direction inputs, registered.
REQ-011 SHALL have ports en1, en2, each output 1: left/right bridge PWM enables, registered.
REQ-012 SHALL have ports feng, beep, led1, each output 1: fan, buzzer, idle LED, registered.

Function
REQ-013 key SHALL pass a 2-FF synchroniser, then a debouncer updating cmd only after DEB_CYC identical samples; decoding: 1000 FWD, 0100 REV, 0010 LEFT, 0001 RIGHT, 0011 STOP, others IDLE.
REQ-014 ena SHALL pass a 2-FF synchroniser without debounce; synchronised ena=1 overrides cmd and forces IDLE.
REQ-015 Direction patterns {zuo1,zuo2,you1,you2}: FWD 1010, REV 0101, LEFT 0010, RIGHT 1000; all 0 in IDLE, STOP, DEAD.
REQ-016 FSM states: IDLE, DEAD, RUN.
REQ-017 IDLE: duty=0, en1=en2=0, led1=1, feng=1 (feng=0 when cmd is STOP and ena=0); motion cmd -> DEAD.
REQ-018 DEAD: bridge and enables 0 for exactly DEAD_CYC cycles, then RUN with duty=0 and latched direction = current cmd; IDLE/STOP cmd -> IDLE immediately.
REQ-019 RUN: led1=0, feng=1, direction per latched cmd; duty +1 every RAMP_DIV cycles until duty==speed; if speed<duty, duty SHALL load speed on the next cycle.
REQ-020 RUN with a different motion cmd -> DEAD (dead-time restarts); IDLE/STOP cmd or ena=1 -> IDLE in one cycle.
REQ-021 A PWM_W-bit counter SHALL free-run and wrap 2^PWM_W-1 -> 0; en1=en2=(pwm_cnt<duty) in RUN only; duty 0 = always low, duty 2^PWM_W-1 = low one cycle per period.
REQ-022 Command arriving mid-DEAD identical to pending direction SHALL NOT restart the dead-time counter.
REQ-023 Outputs SHALL change only on the clk edge following their cause; no combinational input-to-output path.

Reset
REQ-024 rst_n=0 SHALL asynchronously force: FSM IDLE, duty 0, all counters 0, cmd IDLE, zuo1=zuo2=you1=you2=en1=en2=beep=0, feng=1, led1=1.
REQ-025 Reset mid-RUN or mid-DEAD SHALL discard the latched direction; after release the block needs a fresh debounced key before movement.

Configuration
REQ-026 With macro CAR_BEEP_EN defined, beep SHALL equal bit 2 of an internal 24-bit cycle counter gated with bit 23 while in RUN or DEAD, else 0.
REQ-027 Without CAR_BEEP_EN, beep SHALL be constant 0 and the beep counter SHALL NOT be synthesised.

Verification (bench params PWM_W=4, DEB_CYC=4, DEAD_CYC=8, RAMP_DIV=2)
REQ-028 Reset release, key=0000, ena=0 -> all direction/en 0, led1=1, feng=1, beep=0 for 100 cycles.
REQ-029 key=1000 held, speed=6 -> DEAD 8 cycles after debounce, then 1010, duty 0..6 stepping every 2 cycles, en high 6 of every 16 cycles.
REQ-030 key 1000 glitched for 3 cycles -> no state change; held 4 cycles -> accepted.
REQ-031 In RUN FWD, key -> 0100 -> 8 cycles 0000 with en low, then 0101 with duty restarting from 0.
REQ-032 In RUN, ena=1 -> outputs 0, led1=1 within 3 cycles; key=0011 with ena=0 -> feng=0.
REQ-033 rst_n pulsed low mid-ramp -> outputs reach reset values asynchronously; with CAR_BEEP_EN undefined beep stays 0 throughout.
